// File: rtl/regfile_mp_if.sv
// Register-file port bundle: decode read addresses, writeback write port, read data and busy.
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
);
  logic                  reg_write;
  logic [AW-1:0]         write_reg;
  logic [XLEN-1:0]       write_data;
  logic [NRD*AW-1:0]     read_reg;
  logic [NRD*XLEN-1:0]   read_data;
  logic                  busy;

  modport master (
    output reg_write, write_reg, write_data, read_reg,
    input  read_data, busy
  );

  modport slave (
    input  reg_write, write_reg, write_data, read_reg,
    output read_data, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired x0 and a synchronous clear sequencer.
// Optional macro RF_BYPASS_EN: forward the write port to matching read ports in the same cycle.
module regfile_mp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);

  localparam int unsigned NREGS = 1 << AW;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [AW-1:0]       r_clr_idx;
  logic [AW-1:0]       w_clr_idx_nxt;
  logic [XLEN-1:0]     r_mem [NREGS];

  logic                w_we;
  logic [AW-1:0]       w_waddr;
  logic [XLEN-1:0]     w_wdata;
  logic                w_busy;
  logic [NRD*XLEN-1:0] w_read_data;

  // State register; reset only restarts the sequencer, array contents are left alone
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  // Next-state and array write-port selection
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;
    unique case (r_state)
      S_CLEAR: begin
        w_we          = 1'b1;
        w_waddr       = r_clr_idx;
        w_clr_idx_nxt = r_clr_idx + AW'(1);
        if (r_clr_idx == AW'(NREGS - 1)) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.reg_write && (bus.write_reg != '0)) begin
          w_we    = 1'b1;
          w_waddr = bus.write_reg;
          w_wdata = bus.write_data;
        end
      end
      default: begin
        w_state_nxt = S_CLEAR;
      end
    endcase
  end

  // Storage array; a write presented on a reset edge is discarded
  always_ff @(posedge clk) begin
    if (!reset && w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  assign w_busy = (r_state == S_CLEAR);

  // Per-port combinational read; x0 and busy force zero
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   w_addr;
    logic [XLEN-1:0] w_rdata;

    assign w_addr = bus.read_reg[p*AW +: AW];

    always_comb begin
      w_rdata = '0;
      if (!w_busy && (w_addr != '0)) begin
`ifdef RF_BYPASS_EN
        if (bus.reg_write && (bus.write_reg == w_addr)) begin
          w_rdata = bus.write_data;
        end else begin
          w_rdata = r_mem[w_addr];
        end
`else
        w_rdata = r_mem[w_addr];
`endif
      end
    end

    assign w_read_data[p*XLEN +: XLEN] = w_rdata;
  end

  assign bus.read_data = w_read_data;
  assign bus.busy      = w_busy;

endmodule
